// File: rtl/tetris_pkg.sv
// tetris_pkg: shared types, constants and helpers for the score display path
package tetris_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Largest value representable in ndig decimal digits
    function automatic int bcd_max(input int ndig);
        int r;
        r = 1;
        for (int i = 0; i < ndig; i++) r = r * 10;
        return r - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial: serial double-dabble converter, one add-3/shift step per cycle
module bin2bcd_serial #(
    parameter int NDIG = 6,
    parameter int W    = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [W-1:0]      bin_in,
    output logic              done,
    output logic [4*NDIG-1:0] bcd
);

    localparam int CW = $clog2(W);

    logic [W-1:0]      r_bin;
    logic [4*NDIG-1:0] r_bcd;
    logic [CW-1:0]     r_cnt;
    logic              r_run;
    logic [4*NDIG-1:0] w_adj;

    assign done = r_run && (r_cnt == CW'(W - 1));
    assign bcd  = r_bcd;

    // Add-3 correction on every nibble that would overflow past 9 after the shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NDIG; i++)
            w_adj[4*i+:4] = (r_bcd[4*i+:4] >= 4'd5) ? r_bcd[4*i+:4] + 4'd3 : r_bcd[4*i+:4];
    end

    // Load on start, then shift {bcd, bin} left once per cycle for W cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_bin <= bin_in;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_bcd <= {w_adj[4*NDIG-2:0], r_bin[W-1]};
            r_bin <= {r_bin[W-2:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
            r_run <= !done;
        end
    end

endmodule

// File: rtl/seg7.sv
// seg7: BCD digit to active-low 7-segment pattern, bit order 6543210 (gfedcba)
module seg7 (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Combinational digit decode; codes above 9 are don't-care
    always_comb begin
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'bxxxxxxx;
        endcase
    end

endmodule

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: accepts a binary score, converts to BCD and drives NDIG HEX digits
// Optional leading-zero blanking when SCORE_DISP_BLANK_EN is defined.
module score_display_ctrl #(
    parameter int NDIG = 6,
    parameter int W    = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [W-1:0]              score_in,
    input  logic                      score_valid,
    output logic                      score_ready,
    output logic                      busy,
    output logic [4*NDIG-1:0]         bcd_out,
    output logic [NDIG-1:0][6:0]      hex
);

    import tetris_pkg::*;

    localparam logic [W-1:0] MAX_W = W'(bcd_max(NDIG));

    if ((64'd1 << W) <= 64'(bcd_max(NDIG))) begin : g_bad_width
        $error("score_display_ctrl: W too narrow for NDIG digits");
    end

    disp_state_t            r_state;
    disp_state_t            w_next;
    logic                   w_accept;
    logic                   w_done;
    logic [W-1:0]           w_sat;
    logic [4*NDIG-1:0]      w_bcd;
    logic [4*NDIG-1:0]      r_bcd;
    logic [NDIG-1:0][6:0]   w_seg;

    assign w_sat   = (score_in > MAX_W) ? MAX_W : score_in;
    assign bcd_out = r_bcd;

    bin2bcd_serial #(.NDIG(NDIG), .W(W)) u_conv (
        .clk    (clk),
        .reset  (reset),
        .start  (w_accept),
        .bin_in (w_sat),
        .done   (w_done),
        .bcd    (w_bcd)
    );

    // State register
    always_ff @(posedge clk) begin
        r_state <= reset ? IDLE : w_next;
    end

    // Next state and handshake outputs
    always_comb begin
        w_next      = r_state;
        score_ready = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                score_ready = 1'b1;
                w_accept    = score_valid;
                w_next      = score_valid ? CONV : IDLE;
            end
            CONV: begin
                busy   = 1'b1;
                w_next = w_done ? COMMIT : CONV;
            end
            COMMIT: begin
                busy   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Displayed value only moves in COMMIT so the digits never show partial results
    always_ff @(posedge clk) begin
        if (reset) r_bcd <= '0;
        else if (r_state == COMMIT) r_bcd <= w_bcd;
    end

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        seg7 u_seg7 (
            .bcd (r_bcd[4*i+:4]),
            .seg (w_seg[i])
        );
`ifdef SCORE_DISP_BLANK_EN
        assign hex[i] = (i > 0 && r_bcd[4*NDIG-1:4*i] == '0) ? SEG_BLANK : w_seg[i];
`else
        assign hex[i] = w_seg[i];
`endif
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl: scoreboard bench with a decimal-arithmetic display model
module tb_score_display_ctrl;

    localparam int NDIG = 6;
    localparam int W    = 20;
    localparam int LAT  = W + 1;

    typedef struct {
        int val;
        int acc;
    } exp_t;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [W-1:0]         score_in = '0;
    logic                 score_valid = 1'b0;
    logic                 score_ready;
    logic                 busy;
    logic [4*NDIG-1:0]    bcd_out;
    logic [NDIG-1:0][6:0] hex;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic last_rst = 1'b1;
    logic mon_on = 1'b0;
    int   last_acc = 0;
    int   disp_model = 0;
    exp_t sb[$];

    score_display_ctrl #(.NDIG(NDIG), .W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .score_in    (score_in),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .busy        (busy),
        .bcd_out     (bcd_out),
        .hex         (hex)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        last_rst <= reset;
    end

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v > pow10(NDIG) - 1) ? pow10(NDIG) - 1 : v;
    endfunction

    function automatic logic [4*NDIG-1:0] bcd_model(input int v);
        logic [4*NDIG-1:0] r;
        for (int i = 0; i < NDIG; i++) r[4*i+:4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [NDIG-1:0][6:0] hex_model(input int v);
        logic [NDIG-1:0][6:0] h;
        for (int i = 0; i < NDIG; i++) begin
            h[i] = SEG_TAB[(v / pow10(i)) % 10];
`ifdef SCORE_DISP_BLANK_EN
            if (i > 0 && v < pow10(i)) h[i] = 7'b1111111;
`endif
        end
        return h;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Called at a negedge; holds valid until the DUT shows ready, returns at the negedge after accept
    task automatic send(input int v);
        int t;
        score_in    = W'(v);
        score_valid = 1'b1;
        t = 0;
        while (!score_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            fail("ready_timeout");
            score_valid = 1'b0;
            return;
        end
        last_acc = cyc + 1;
        sb.push_back('{sat(v), cyc + 1});
        @(negedge clk);
        score_valid = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_ready"}, 64'(score_ready), 64'd1);
        chk({tag, "_bcd"}, 64'(bcd_out), 64'd0);
    endtask

    // Monitor: pops an expectation whenever a conversion completes, and checks the display every cycle
    initial begin
        logic prev_busy;
        logic bad;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (last_rst) begin
                    disp_model = 0;
                end else if (prev_busy && !busy) begin
                    if (sb.size() == 0) begin
                        fail("commit_unexpected");
                    end else begin
                        e = sb.pop_front();
                        chk("commit_latency", 64'(cyc), 64'(e.acc + LAT));
                        disp_model = e.val;
                    end
                end
                if (sb.size() > 0 && cyc > sb[0].acc + LAT) begin
                    fail("commit_overdue");
                    void'(sb.pop_front());
                end
                chk("bcd_out", 64'(bcd_out), 64'(bcd_model(disp_model)));
                chk("hex", 64'(hex), 64'(hex_model(disp_model)));
                bad = 1'b0;
                for (int i = 0; i < NDIG; i++) bad |= (bcd_out[4*i+:4] > 4'd9);
                chk("nibble_le9", 64'(bad), 64'd0);
            end
            prev_busy = busy;
        end
    end

    initial begin
        int a1;
        int t;
        int v;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mon_on = 1'b1;
        check_idle_zero("reset");
        chk("reset_hex", 64'(hex), 64'(hex_model(0)));

        send(1234);
        a1 = last_acc;
        send(77);
        chk("held_accept_cycle", 64'(last_acc), 64'(a1 + W + 2));

        send(1048575);
        send(1000000);

        @(negedge clk);
        send(555555);
        while (cyc < last_acc + 10) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        score_in    = W'(4321);
        score_valid = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        score_valid = 1'b0;
        check_idle_zero("abort");
        repeat (2) @(negedge clk);
        check_idle_zero("abort_after");

        foreach (SEG_TAB[k]) begin
            if (k == 0) begin
                send(9);
                send(10);
                send(99);
                send(100);
                send(999999);
            end
        end

        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 3))
                0: v = int'($urandom_range(0, (1 << W) - 1));
                1: v = int'($urandom_range(0, 999));
                2: v = int'($urandom_range(999990, 1000010));
                default: v = int'($urandom_range(0, 999999));
            endcase
            send(v);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        t = 0;
        while (sb.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() > 0) fail("drain_timeout");
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
